// File: rtl/mvm_pkg.sv
// Shared definitions for the mvm family: FSM states, default sizes and
// bit-offset helpers for the packed matrix/vector layout ((0,0) in the MSBs).
package mvm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } mvm_state_e;

    localparam int DEF_MATRIX_ROWS = 3;
    localparam int DEF_SHARED_DIM  = 3;
    localparam int DEF_WIDTH       = 8;

    // LSB of element (i,j) in a row-major matrix whose first element is most significant.
    function automatic int mat_lsb(input int i, input int j, input int rows,
                                   input int cols, input int width);
        return (rows * cols - 1 - (i * cols + j)) * width;
    endfunction

    // LSB of element i in a vector whose first element is most significant.
    function automatic int vec_lsb(input int i, input int len, input int width);
        return (len - 1 - i) * width;
    endfunction

endpackage

// File: rtl/mvm_mac_lane.sv
// One result column: a multiplier feeding a clearable accumulator. acc_next is
// the running sum including the current product, so the owner can latch it on the last row.
module mvm_mac_lane #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 18
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [ACC_W-1:0] acc_next
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] prod;

    always_comb begin
        prod     = ACC_W'(a) * ACC_W'(b);
        acc_next = acc_q + prod;
        acc_d    = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/mvm_transpose.sv
// Transpose matrix-vector product: result[j] = sum_i matrix(i,j)*vector(i),
// one matrix row per cycle with SHARED_DIM lanes accumulating in parallel.
module mvm_transpose
    import mvm_pkg::*;
#(
    parameter int MATRIX_ROWS = DEF_MATRIX_ROWS,
    parameter int SHARED_DIM  = DEF_SHARED_DIM,
    parameter int WIDTH       = DEF_WIDTH
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    start,
    input  logic [MATRIX_ROWS*SHARED_DIM*WIDTH-1:0] matrix,
    input  logic [MATRIX_ROWS*WIDTH-1:0]            vector,
    output logic [SHARED_DIM*WIDTH-1:0]             result_vector,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    overflow,
    output mvm_state_e                              state_dbg
);

    localparam int ACC_W = 2 * WIDTH + $clog2(MATRIX_ROWS);
    localparam int ROW_W = (MATRIX_ROWS > 1) ? $clog2(MATRIX_ROWS) : 1;

    mvm_state_e                              state_q, state_d;
    logic [ROW_W-1:0]                        row_q, row_d;
    logic [MATRIX_ROWS*SHARED_DIM*WIDTH-1:0] mat_q, mat_d;
    logic [MATRIX_ROWS*WIDTH-1:0]            vec_q, vec_d;
    logic [SHARED_DIM*WIDTH-1:0]             result_q, result_d;
    logic                                    busy_q, busy_d;
    logic                                    done_q, done_d;
    logic                                    ovf_q, ovf_d;

    logic                                    lane_clear;
    logic                                    lane_en;
    logic                                    last_row;
    logic [WIDTH-1:0]                        mat_arr [MATRIX_ROWS][SHARED_DIM];
    logic [WIDTH-1:0]                        vec_arr [MATRIX_ROWS];
    logic [ACC_W-1:0]                        lane_sum [SHARED_DIM];

    // Unpack the captured operands so a row can be selected by row_q alone.
    for (genvar i = 0; i < MATRIX_ROWS; i++) begin : g_row
        assign vec_arr[i] = vec_q[vec_lsb(i, MATRIX_ROWS, WIDTH) +: WIDTH];
        for (genvar j = 0; j < SHARED_DIM; j++) begin : g_col
            assign mat_arr[i][j] = mat_q[mat_lsb(i, j, MATRIX_ROWS, SHARED_DIM, WIDTH) +: WIDTH];
        end
    end

    assign lane_clear = (state_q == IDLE) && start;
    assign lane_en    = (state_q == ACCUM);
    assign last_row   = (row_q == ROW_W'(MATRIX_ROWS - 1));

    for (genvar j = 0; j < SHARED_DIM; j++) begin : g_lane
        mvm_mac_lane #(
            .WIDTH (WIDTH),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk      (clk),
            .reset_n  (reset_n),
            .clear    (lane_clear),
            .en       (lane_en),
            .a        (mat_arr[row_q][j]),
            .b        (vec_arr[row_q]),
            .acc_next (lane_sum[j])
        );
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        mat_d    = mat_q;
        vec_d    = vec_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    row_d   = '0;
                    mat_d   = matrix;
                    vec_d   = vector;
                    busy_d  = 1'b1;
                end
            end
            ACCUM: begin
                busy_d = 1'b1;
                row_d  = row_q + 1'b1;
                if (last_row) begin
                    // Latch the final sums (last row included) so done and data align.
                    state_d = DONE;
                    row_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ovf_d   = 1'b0;
                    for (int j = 0; j < SHARED_DIM; j++) begin
                        result_d[vec_lsb(j, SHARED_DIM, WIDTH) +: WIDTH] = lane_sum[j][WIDTH-1:0];
                        if (lane_sum[j][ACC_W-1:WIDTH] != '0) begin
                            ovf_d = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            row_q    <= '0;
            mat_q    <= '0;
            vec_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            mat_q    <= mat_d;
            vec_q    <= vec_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result_vector = result_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign overflow      = ovf_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_mvm_transpose.sv
// Bench for mvm_transpose: directed and random operations checked against an
// arithmetic reference model, with cycle-accurate busy/done timing checks.
module tb_mvm_transpose;

  localparam int M = 3;
  localparam int N = 3;
  localparam int W = 8;
  localparam int RW = N * W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  logic start;
  logic [M*N*W-1:0] matrix;
  logic [M*W-1:0] vector;
  logic [N*W-1:0] result_vector;
  logic busy;
  logic done;
  logic overflow;
  mvm_pkg::mvm_state_e state_dbg;

  always #5 clk = ~clk;

  mvm_transpose #(
    .MATRIX_ROWS (M),
    .SHARED_DIM  (N),
    .WIDTH       (W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .matrix        (matrix),
    .vector        (vector),
    .result_vector (result_vector),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .state_dbg     (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_bad = 0;
  logic [RW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain sums of products per column, {overflow, low bits}.
  function automatic logic [RW-1:0] model(input logic [M*N*W-1:0] m, input logic [M*W-1:0] v);
    logic [N*W-1:0] r;
    logic o;
    int unsigned s;
    int unsigned a;
    int unsigned b;
    r = '0;
    o = 1'b0;
    for (int j = 0; j < N; j++) begin
      s = 0;
      for (int i = 0; i < M; i++) begin
        a = int'(m[(M*N-1-(i*N+j))*W +: W]);
        b = int'(v[(M-1-i)*W +: W]);
        s = s + a * b;
      end
      r[(N-1-j)*W +: W] = W'(s % (1 << W));
      if (s > (1 << W) - 1) o = 1'b1;
    end
    return {o, r};
  endfunction

  // ---------------- driver ----------------
  // One operation: start at a negedge, then watch busy/done for a bounded window.
  // disturb: change operands and pulse start during ACCUM and again during DONE.
  task automatic run_op(input string tag, input logic [M*N*W-1:0] m, input logic [M*W-1:0] v,
                        input bit disturb, input bit release_rst);
    logic [RW-1:0] exp;
    logic [RW-1:0] last_exp;
    int busy_cnt;
    int done_cnt;
    int lat;
    busy_cnt = 0;
    done_cnt = 0;
    lat = 0;
    last_exp = model(m, v);
    exp_q.push_back(last_exp);
    @(negedge clk);
    if (release_rst) reset_n = 1'b1;
    matrix = m;
    vector = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= M + 3; c++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        lat = c;
        if (exp_q.size() == 0) begin
          check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
          exp = exp_q.pop_front();
          check({tag, "_result"}, 64'(result_vector), 64'(exp[N*W-1:0]));
          check({tag, "_ovf"}, 64'(overflow), 64'(exp[RW-1]));
        end
      end
      start = 1'b0;
      if (disturb && (c == 2 || c == M + 1)) begin
        matrix = M*N*W'({$urandom, $urandom, $urandom});
        vector = M*W'($urandom);
        start = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(M));
    check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(M + 1));
    check({tag, "_hold"}, 64'(result_vector), 64'(last_exp[N*W-1:0]));
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [M*N*W-1:0] rm;
    logic [M*W-1:0] rv;
    int done_seen;

    reset_n = 1'b0;
    start = 1'b0;
    matrix = '0;
    vector = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", 64'(result_vector), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(mvm_pkg::IDLE));

    // First start shares its edge with reset release.
    run_op("basic", 72'h010203040506070809, 24'h010203, 1'b0, 1'b1);
    check("basic_const", 64'(result_vector), 64'h1E242A);
    run_op("dir2", 72'h0A0B0C0D0E0F101111, 24'h040506, 1'b0, 1'b0);
    check("dir2_const", 64'(result_vector), 64'hC9D8E1);
    run_op("allff", {9{8'hFF}}, 24'h010101, 1'b0, 1'b0);
    check("allff_const", 64'(result_vector), 64'hFDFDFD);
    check("allff_ovf_const", 64'(overflow), 64'd1);
    run_op("ident", 72'h010000000100000001, 24'h0A0B0C, 1'b1, 1'b0);
    check("ident_const", 64'(result_vector), 64'h0A0B0C);

    // Reset during the second busy cycle aborts the operation.
    @(negedge clk);
    matrix = 72'h010203040506070809;
    vector = 24'h010203;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("abort_busy1", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_result", 64'(result_vector), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_ovf", 64'(overflow), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < M + 3; c++) begin
      if (done) done_seen++;
      @(posedge clk);
      #1;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    check("abort_no_busy", 64'(busy), 64'd0);
    run_op("after_abort", 72'h010203040506070809, 24'h010203, 1'b0, 1'b0);
    check("after_abort_const", 64'(result_vector), 64'h1E242A);

    // Random operations: mix of full-range and small operands, some disturbed.
    for (int t = 0; t < 12; t++) begin
      for (int e = 0; e < M * N; e++) begin
        rm[e*W +: W] = (t % 3 == 0) ? W'($urandom_range(0, 15)) : W'($urandom_range(0, 255));
      end
      for (int e = 0; e < M; e++) begin
        rv[e*W +: W] = (t % 3 == 0) ? W'($urandom_range(0, 15)) : W'($urandom_range(0, 255));
      end
      run_op($sformatf("rand%0d", t), rm, rv, bit'(t % 2), 1'b0);
    end

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  // Safety net: the run must never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
